// File: rtl/time_sync_pkg.sv
// time_sync_pkg: register map, response codes and ID constant for the time-sync register file.
package time_sync_pkg;
    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_INCR    = 5'h04;
    localparam logic [4:0] OFF_LOAD_LO = 5'h08;
    localparam logic [4:0] OFF_LOAD_HI = 5'h0C;
    localparam logic [4:0] OFF_TS_LO   = 5'h10;
    localparam logic [4:0] OFF_TS_HI   = 5'h14;
    localparam logic [4:0] OFF_ID      = 5'h18;
    localparam logic [4:0] OFF_RSVD    = 5'h1C;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] ID_DEFAULT = 32'h7453_0100;
    typedef enum logic [2:0] {
        REG_CTRL, REG_INCR, REG_LOAD_LO, REG_LOAD_HI,
        REG_TS_LO, REG_TS_HI, REG_ID, REG_RSVD
    } reg_idx_e;
endpackage

// File: rtl/time_sync_axil_regs_if.sv
// time_sync_axil_regs_if: AXI4-Lite bus between the VIP master and the time-sync register file.
interface time_sync_axil_regs_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid, awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid, wready;
    logic [1:0]      bresp;
    logic            bvalid, bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid, arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid, rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/time_sync_counter.sv
// time_sync_counter: 64-bit timestamp accumulator with priority load and high-word shadow capture.
module time_sync_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_val,
    input  logic        en,
    input  logic [31:0] incr,
    input  logic        capture,
    output logic [63:0] count,
    output logic [31:0] shadow
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            shadow <= '0;
        end else begin
            if (load) count <= load_val;
            else if (en) count <= count + {32'd0, incr};
            if (capture) shadow <= count[63:32];
        end
    end
endmodule

// File: rtl/time_sync_axil_regs.sv
// time_sync_axil_regs: AXI4-Lite register file with config registers and a free-running timestamp.
module time_sync_axil_regs
    import time_sync_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_ID_VALUE         = ID_DEFAULT
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    time_sync_axil_regs_if.slave  s_axi,
    output logic [63:0]           ts_count
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    logic                          live, aw_full, w_full, aw_hs, w_hs, ar_hs, commit, wr_rw, unused_ok;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
    logic [DW-1:0]                 w_data_q, wr_data, merged, rd_val;
    logic [DW/8-1:0]               w_strb_q, wr_strb;
    logic [DW-1:0]                 regs [4];
    logic [31:0]                   shadow;
    reg_idx_e                      wr_idx, rd_idx;

    // live keeps every ready low until the first edge after reset is released
    assign s_axi.awready = live & ~aw_full & ~s_axi.bvalid;
    assign s_axi.wready  = live & ~w_full & ~s_axi.bvalid;
    assign s_axi.arready = live & ~s_axi.rvalid;
    assign s_axi.rresp   = RESP_OKAY;
    assign aw_hs   = s_axi.awvalid & s_axi.awready;
    assign w_hs    = s_axi.wvalid & s_axi.wready;
    assign ar_hs   = s_axi.arvalid & s_axi.arready;
    assign commit  = (aw_full | aw_hs) & (w_full | w_hs);
    assign wr_addr = aw_full ? aw_addr_q : s_axi.awaddr;
    assign wr_data = w_full ? w_data_q : s_axi.wdata;
    assign wr_strb = w_full ? w_strb_q : s_axi.wstrb;
    assign wr_idx  = reg_idx_e'(wr_addr[4:2]);
    assign rd_idx  = reg_idx_e'(s_axi.araddr[4:2]);
    assign wr_rw   = ~wr_addr[4];
    assign unused_ok = ^{wr_addr[1:0], s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot};

    always_comb begin
        merged = regs[wr_addr[3:2]];
        for (int i = 0; i < DW/8; i++) if (wr_strb[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end

    assign rd_val = !s_axi.araddr[4]     ? regs[s_axi.araddr[3:2]]
                  : rd_idx == REG_TS_LO ? ts_count[31:0]
                  : rd_idx == REG_TS_HI ? shadow
                  : rd_idx == REG_ID    ? C_ID_VALUE : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live         <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            regs         <= '{default: '0};
            s_axi.bvalid <= 1'b0;
            s_axi.bresp  <= RESP_OKAY;
            s_axi.rvalid <= 1'b0;
            s_axi.rdata  <= '0;
        end else begin
            live    <= 1'b1;
            aw_full <= ~commit & (aw_full | aw_hs);
            w_full  <= ~commit & (w_full | w_hs);
            if (aw_hs) aw_addr_q <= s_axi.awaddr;
            if (w_hs) begin
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (commit && wr_rw) regs[wr_addr[3:2]] <= merged;
            if (commit) s_axi.bresp <= wr_rw ? RESP_OKAY : RESP_SLVERR;
            s_axi.bvalid <= commit | (s_axi.bvalid & ~s_axi.bready);
            if (ar_hs) s_axi.rdata <= rd_val;
            s_axi.rvalid <= ar_hs | (s_axi.rvalid & ~s_axi.rready);
        end
    end

    // LOAD_HI commit loads the counter with the merged high word and the stored low word
    time_sync_counter u_counter (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .load     (commit && wr_idx == REG_LOAD_HI),
        .load_val ({merged, regs[2]}),
        .en       (regs[0][0]),
        .incr     (regs[1]),
        .capture  (ar_hs && rd_idx == REG_TS_LO),
        .count    (ts_count),
        .shadow   (shadow)
    );
endmodule

// File: doc/time_sync_axil_regs.md
# time_sync_axil_regs

AXI4-Lite slave register file for the time-sync block. It is the responder that the block's AXI VIP master bench drives.
- Holds four read/write configuration registers.
- Owns a free-running 64-bit timestamp counter, exposed as read-only registers with a coherent high-word snapshot.
- Sits directly behind the block's S00_AXI port.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; decode uses addr[4:2].
- C_ID_VALUE, 32'h7453_0100: constant returned at 0x18.
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- s_axi_awaddr, s_axi_awprot  in  5/3  write address, prot (prot ignored); s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata, s_axi_wstrb  in  32/4  write data, byte strobes; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr, s_axi_arprot  in  5/3; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata, s_axi_rresp  out  32/2; s_axi_rvalid out 1; s_axi_rready in 1.
- ts_count  out  64  live counter value for the datapath.

## Operation
- Register map:
  - 0x00 CTRL, RW: bit0 = count enable.
  - 0x04 INCR, RW: added to the counter each enabled cycle.
  - 0x08 LOAD_LO, RW.
  - 0x0C LOAD_HI, RW: any write to it also loads the counter with {LOAD_HI, LOAD_LO} using the post-write values.
  - 0x10 TS_LO, RO: returns counter[31:0] and captures counter[63:32] into the shadow register.
  - 0x14 TS_HI, RO: returns the shadow.
  - 0x18 ID, RO: returns C_ID_VALUE.
  - 0x1C, RO: returns 0.
- RW registers store all 32 bits and read back exactly what was written. Byte lanes follow wstrb; wstrb=0 changes nothing but still returns a response.
- Writes to 0x10–0x1C change nothing and return BRESP=SLVERR (2'b10). All other writes return OKAY. All reads return OKAY.
- Counter:
  - When enabled: counter <= counter + INCR, modulo 2^64; wrap-around is silent.
  - A load and an increment in the same cycle: the load wins.
  - When disabled, the counter holds its value.
- Write channel:
  - AW and W are accepted independently into one-deep holding registers.
  - awready is low while the AW holding register is full or bvalid is high; the same rule applies to wready.
  - Write commits once both holding registers are full.
- Read channel: arready is low while rvalid is high; there is one outstanding read.

## Timing
- Reset values:
  - All ready and valid outputs: 0. bresp, rresp, rdata: 0.
  - All registers, the counter and the shadow: 0. ts_count: 0.
- From the first edge after ARESETN rises: awready, wready and arready = 1.
- Write latency:
  - AW and W handshakes in the same cycle N: register updated and bvalid=1 at edge N+1.
  - AW and W in different cycles: commit is one edge after the later handshake.
  - bvalid and bresp hold until the bready handshake. awready and wready return to 1 in the cycle after that handshake.
- Read latency: AR handshake in cycle N gives rvalid and rdata at N+1. rdata is stable until the rready handshake.
- A read in cycle N of a register being committed at edge N+1 returns the old value.
- Counter after a LOAD_HI write: the loaded value is visible at ts_count at the commit edge. Increments resume at the next edge.
- Reset mid-transaction: all state clears asynchronously and the in-flight transaction is dropped without a response.

## Structure
- Package time_sync_pkg holds:
  - register offset localparams;
  - RESP_OKAY and RESP_SLVERR;
  - the default ID constant;
  - a register-index enum.
- Sub-module time_sync_counter:
  - 64-bit accumulator with load (priority), enable and increment inputs;
  - shadow-capture strobe; outputs count and shadow.
- The top level contains the AXI channel logic, register decode and byte-lane merge.

## Test plan
- Write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read them back → 1, 2, 3, 4, all with OKAY responses.
- Write LOAD_LO=0xFFFF_FFFE and LOAD_HI=0xFFFF_FFFF, INCR=1, then CTRL=1 → after 3 enabled cycles the counter reads 1 (wrap); read TS_LO then TS_HI → coherent pair.
- Write W 3 cycles before AW, holding bready=0 for 4 cycles → one commit, bvalid held, awready/wready stay 0 until the bready handshake.
- Write 0xAABBCCDD with wstrb=4'b0101 to INCR (previous value 0) → readback 0x00BB00DD.
- Write to 0x18 → BRESP=SLVERR; ID read still returns C_ID_VALUE.
- Deassert ARESETN while bvalid=1 → every output is 0 immediately; after release, the registers read 0 and readies return to 1.
